// File: rtl/processor_controller.sv
// Multi-cycle control unit: PC/IR, fetch/decode/execute sequencing, memory/register-file/ALU controls.
// Optional CTRL_STEP_EN adds a Step input that gates FETCH -> DECODE for single-stepping.
module processor_controller #(
  parameter int unsigned PC_W = 7
) (
  input  logic            Clk,
  input  logic            Reset,
`ifdef CTRL_STEP_EN
  input  logic            Step,
`endif
  input  logic [15:0]     Instr,
  output logic [PC_W-1:0] PC_Addr,
  output logic [7:0]      D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      ALU_s0,
  output logic            Halted,
  output logic [3:0]      State
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ALU    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_INC   = 4'd9;

  localparam logic [2:0] ALU_ZERO  = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_PASSA = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_OR    = 3'd5;
  localparam logic [2:0] ALU_AND   = 3'd6;
  localparam logic [2:0] ALU_INCA  = 3'd7;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;

  logic [3:0] ir_op, ir_ra, ir_rb, ir_rd;
  logic [7:0] ir_d;

  assign ir_op = ir[15:12];
  assign ir_ra = ir[11:8];
  assign ir_rb = ir[7:4];
  assign ir_rd = ir[3:0];
  assign ir_d  = ir[7:0];

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_XOR:  return ALU_XOR;
      OP_OR:   return ALU_OR;
      OP_AND:  return ALU_AND;
      OP_INC:  return ALU_INCA;
      default: return ALU_ZERO;
    endcase
  endfunction

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  // PC and IR; IR captures the instruction word in DECODE, PC wraps naturally
  always_ff @(posedge Clk) begin
    if (Reset || state == S_INIT) begin
      pc <= '0;
      ir <= '0;
    end else if (state == S_DECODE) begin
      ir <= Instr;
      pc <= pc + PC_W'(1);
    end
  end

  // Next-state logic; DECODE dispatches on the incoming word since IR is not yet loaded
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
`ifdef CTRL_STEP_EN
      S_FETCH:  state_nxt = Step ? S_DECODE : S_FETCH;
`else
      S_FETCH:  state_nxt = S_DECODE;
`endif
      S_DECODE: begin
        case (Instr[15:12])
          OP_LOAD:  state_nxt = S_LOAD_A;
          OP_STORE: state_nxt = S_STORE;
          OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_INC: state_nxt = S_ALU;
          OP_HALT:  state_nxt = S_HALT;
          default:  state_nxt = S_NOOP;
        endcase
      end
      S_NOOP:   state_nxt = S_FETCH;
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_FETCH;
      S_STORE:  state_nxt = S_FETCH;
      S_ALU:    state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_INIT;
    endcase
  end

  // Moore outputs from state and IR
  always_comb begin
    PC_Addr    = pc;
    D_Addr     = 8'd0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'd0;
    RF_Rb_addr = 4'd0;
    ALU_s0     = ALU_ZERO;
    Halted     = 1'b0;
    State      = state;
    case (state)
      S_LOAD_A: D_Addr = ir_d;
      S_LOAD_B: begin
        D_Addr    = ir_d;
        RF_s      = 1'b1;
        RF_W_addr = ir_ra;
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_Addr     = ir_d;
        RF_Ra_addr = ir_ra;
        ALU_s0     = ALU_PASSA;
        D_Wr       = 1'b1;
      end
      S_ALU: begin
        RF_Ra_addr = ir_ra;
        RF_Rb_addr = ir_rb;
        RF_W_addr  = ir_rd;
        RF_W_en    = 1'b1;
        ALU_s0     = alu_sel(ir_op);
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_processor_controller.sv
// Randomized scoreboard bench for processor_controller against an instruction-level timing model.
module tb_processor_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Instr = 16'd0;
  logic [6:0]  PC_Addr;
  logic [7:0]  D_Addr;
  logic        D_Wr, RF_s, RF_W_en, Halted;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s0;
`ifdef CTRL_STEP_EN
  logic        Step = 1'b1;
`endif

  always #5 Clk = ~Clk;

  processor_controller #(.PC_W(7)) dut (
    .Clk(Clk), .Reset(Reset),
`ifdef CTRL_STEP_EN
    .Step(Step),
`endif
    .Instr(Instr), .PC_Addr(PC_Addr), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0), .Halted(Halted), .State(State)
  );

  // Synchronous-read instruction memory
  logic [15:0] imem [128];
  always @(posedge Clk) Instr <= imem[PC_Addr];

  // Cycle index: 0 is the INIT cycle after the last reset edge, 1 the first FETCH
  int cyc = 0;
  always @(posedge Clk) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic        dwr;
    logic [7:0]  d;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  wa;
    logic        s;
    logic [2:0]  alu;
  } ev_t;

  ev_t q[$];
  int errors = 0;
  int checks = 0;

  function automatic ev_t mk_ev(input int c, input logic dwr, input logic [7:0] d,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [3:0] wa, input logic s, input logic [2:0] alu);
    ev_t e;
    e.cyc = 32'(c); e.dwr = dwr; e.d = d; e.ra = ra; e.rb = rb; e.wa = wa; e.s = s; e.alu = alu;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ALU select codes named by function: ZERO 0, ADD 1, SUB 2, PASS_A 3, XOR 4, OR 5, AND 6, INC_A 7
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'd3: return 3'd1;
      4'd4: return 3'd2;
      4'd6: return 3'd4;
      4'd7: return 3'd5;
      4'd8: return 3'd6;
      4'd9: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Instruction-level model: CPI table plus the single write each instruction makes
  task automatic run_model(input int ninstr, output int end_cyc, output logic [6:0] end_pc,
                           output bit halted, output int halt_cyc);
    int c;
    logic [6:0] pc;
    logic [15:0] w;
    c = 1; pc = 7'd0; halted = 1'b0; halt_cyc = 0;
    for (int i = 0; i < ninstr && !halted; i++) begin
      w = imem[pc];
      pc = pc + 7'd1;
      case (w[15:12])
        4'd1: begin
          q.push_back(mk_ev(c + 2, 1'b1, w[7:0], w[11:8], 4'd0, 4'd0, 1'b0, 3'd3));
          c += 3;
        end
        4'd2: begin
          q.push_back(mk_ev(c + 3, 1'b0, w[7:0], 4'd0, 4'd0, w[11:8], 1'b1, 3'd0));
          c += 4;
        end
        4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9: begin
          q.push_back(mk_ev(c + 2, 1'b0, 8'd0, w[11:8], w[7:4], w[3:0], 1'b0, alu_code(w[15:12])));
          c += 3;
        end
        4'd5: begin
          halted = 1'b1;
          halt_cyc = c + 2;
        end
        default: c += 3;
      endcase
    end
    end_cyc = c;
    end_pc = pc;
  endtask

  // Monitor: every write strobe must match the next expected event, including its cycle
  always @(negedge Clk) begin : monitor
    ev_t got, exp;
    if (!Reset && (D_Wr || RF_W_en)) begin
      got = mk_ev(cyc, D_Wr, D_Addr, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_s, ALU_s0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h at cycle %0d, none expected", got, cyc);
      end else begin
        exp = q.pop_front();
        check("write_event", 64'(got), 64'(exp));
      end
      check("wr_exclusive", 64'(D_Wr & RF_W_en), 64'd0);
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge Clk);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #1 Reset = 1'b1;
    q.delete();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("init_outputs",
          64'({PC_Addr, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr,
               ALU_s0, Halted, State}), 64'd0);
  endtask

  task automatic run_prog(input string name, input int ninstr);
    int ec, hc;
    logic [6:0] ep;
    bit h;
    do_reset();
    run_model(ninstr, ec, ep, h, hc);
    if (h) begin
      wait_cyc(hc - 1);
      check({name, "_not_halted_early"}, 64'(Halted), 64'd0);
      wait_cyc(hc);
      check({name, "_halted"}, 64'(Halted), 64'd1);
      check({name, "_halt_state"}, 64'(State), 64'd8);
      check({name, "_halt_pc"}, 64'(PC_Addr), 64'(ep));
      wait_cyc(hc + 6);
      check({name, "_stays_halted"}, 64'({Halted, State}), 64'({1'b1, 4'd8}));
    end else begin
      wait_cyc(ec);
      check({name, "_end_state"}, 64'(State), 64'd1);
      check({name, "_end_pc"}, 64'(PC_Addr), 64'(ep));
    end
    check({name, "_queue_drained"}, 64'(q.size()), 64'd0);
  endtask

  function automatic logic [15:0] rand_word(input bit allow_halt);
    logic [3:0] op;
    if (allow_halt && $urandom_range(0, 39) == 0) op = 4'd5;
    else begin
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd5) op = op + 4'd1;
    end
    return {op, 12'($urandom())};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int ec, hc;
    logic [6:0] ep;
    bit h;

    // Two loads, an add, then halt: halt is reached on cycle 14 with PC = 4
    clear_imem();
    imem[0] = 16'h2105; imem[1] = 16'h2206; imem[2] = 16'h3123; imem[3] = 16'h5000;
    run_prog("prog", 10);

    // Each ALU opcode in turn
    clear_imem();
    imem[0] = {4'd4, 12'($urandom())};
    imem[1] = {4'd6, 12'($urandom())};
    imem[2] = {4'd7, 12'($urandom())};
    imem[3] = {4'd8, 12'($urandom())};
    imem[4] = {4'd9, 12'($urandom())};
    imem[5] = 16'h5000;
    run_prog("alu_seq", 10);

    clear_imem();
    imem[0] = 16'h1A3F; imem[1] = 16'h5000;
    run_prog("store", 5);

    // NOOP-class opcodes straight through the PC wrap
    for (int i = 0; i < 128; i++)
      imem[i] = ($urandom_range(0, 1) == 0) ? {4'h0, 12'($urandom())} :
                {4'($urandom_range(10, 15)), 12'($urandom())};
    imem[127] = 16'h0000; imem[126] = 16'hC000;
    run_prog("noop_wrap", 130);

    // Reset in the middle of a load
    clear_imem();
    imem[0] = 16'h2105;
    do_reset();
    run_model(1, ec, ep, h, hc);
    wait_cyc(4);
    check("midload_state", 64'({State, RF_W_en}), 64'({4'd5, 1'b1}));
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("midload_reset_state", 64'(State), 64'd0);
    check("midload_reset_pc", 64'(PC_Addr), 64'd0);
    check("midload_reset_enables", 64'({RF_W_en, D_Wr}), 64'd0);
    Reset = 1'b0;
    check("midload_queue", 64'(q.size()), 64'd0);

    // Random programs without halt, wrapping PC several times
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 128; i++) imem[i] = rand_word(1'b0);
      run_prog("random", 250);
    end
    // Random programs that may halt
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 128; i++) imem[i] = rand_word(1'b1);
      run_prog("random_halt", 250);
    end

    // Reset out of HALT
    clear_imem();
    imem[0] = 16'h5000;
    run_prog("halt_only", 3);
    run_prog("halt_again", 3);

`ifdef CTRL_STEP_EN
    clear_imem();
    Step = 1'b0;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      wait_cyc(i);
      check("step_hold", 64'({State, PC_Addr}), 64'({4'd1, 7'd0}));
    end
    Step = 1'b1;
    @(negedge Clk);
    Step = 1'b0;
    check("step_decode", 64'(State), 64'd2);
    @(negedge Clk);
    check("step_noop", 64'(State), 64'd3);
    repeat (4) begin
      @(negedge Clk);
      check("step_hold_after", 64'({State, PC_Addr}), 64'({4'd1, 7'd1}));
    end
    Step = 1'b1;
`endif

    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
